shr_frame: RTL and testbench

SHR_FRAME -- requirements
Module: shr_frame

---
 rtl/shr_pkg.sv | 19 +
 rtl/shr_bitcnt.sv | 40 ++++
 rtl/shr_frame.sv | 115 +++++++++++
 tb/tb_shr_frame.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shr_pkg.sv
// shr_pkg: shared definitions for the shr_frame shift-register framer.
//   state_t        - framer FSM state encoding
//   DEFAULT_WIDTH  - default register / frame length in bits
//   cnt_width()    - bit counter width needed to hold the values 0..w
package shr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shr_bitcnt.sv
// shr_bitcnt: frame bit counter for shr_frame.
//   i_sysclk  - system clock, rising edge
//   i_sysrst  - asynchronous active-low reset, clears the count
//   i_clr     - synchronous clear (start of a frame)
//   i_en      - count one shifted bit
//   o_tc      - terminal-count flag: the next enabled increment brings the
//               count to WIDTH, i.e. it is the last bit of the frame
import shr_pkg::*;

module shr_bitcnt #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic i_sysclk,
  input  logic i_sysrst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] count;

  // Saturates at WIDTH so the count can never wrap inside a frame, even if
  // the enable were held after the last bit.
  always_ff @(posedge i_sysclk or negedge i_sysrst) begin
    if (!i_sysrst) begin
      count <= '0;
    end else if (i_clr) begin
      count <= '0;
    end else if (i_en && (count != CW'(WIDTH))) begin
      count <= count + 1'b1;
    end
  end

  // Flag is taken from the registered count only (not the enable) so the
  // FSM can combine it with its own enable without a combinational loop.
  assign o_tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/shr_frame.sv
// shr_frame: parallel-load shift register with WIDTH-bit framed transfer.
//   i_sysclk   - system clock, all state changes on the rising edge
//   i_sysrst   - asynchronous active-low reset
//   i_din      - serial input (unused when FEEDBACK=1)
//   i_sh       - shift enable, one bit per high cycle
//   i_ld       - parallel load without starting a frame
//   i_start    - parallel load and start a WIDTH-bit frame (wins over i_ld)
//   i_ld_data  - parallel load value
//   o_dout     - serial output, the register end bit (combinational)
//   o_dstr     - register contents
//   o_busy     - high while a frame is being shifted
//   o_done     - one-cycle pulse when the frame completes
// Parameters: WIDTH (2..32), MSB_FIRST (1: shift toward MSB, 0: toward LSB),
// FEEDBACK (0: serial input from i_din, 1: rotate).
import shr_pkg::*;

module shr_frame #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1,
  parameter int FEEDBACK  = 0
) (
  input  logic             i_sysclk,
  input  logic             i_sysrst,
  input  logic             i_din,
  input  logic             i_sh,
  input  logic             i_ld,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_ld_data,
  output logic             o_dout,
  output logic [WIDTH-1:0] o_dstr,
  output logic             o_busy,
  output logic             o_done
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [WIDTH-1:0] shifted;
  logic             shift_in;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;

  assign o_dout   = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign o_dstr   = shreg;
  assign shift_in = (FEEDBACK != 0) ? o_dout : i_din;
  assign shifted  = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], shift_in}
                                     : {shift_in, shreg[WIDTH-1:1]};

  shr_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .i_sysclk (i_sysclk),
    .i_sysrst (i_sysrst),
    .i_clr    (cnt_clr),
    .i_en     (cnt_en),
    .o_tc     (cnt_tc)
  );

  // Next state and next register value. IDLE keeps the legacy free-running
  // shift when nothing is loaded; once a frame is running, load and start
  // strobes are ignored until the DONE cycle has passed.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          shreg_nxt = i_ld_data;
          cnt_clr   = 1'b1;
          state_nxt = SHIFT;
        end else if (i_ld) begin
          shreg_nxt = i_ld_data;
        end else if (i_sh) begin
          shreg_nxt = shifted;
        end
      end
      SHIFT: begin
        if (i_sh) begin
          shreg_nxt = shifted;
          cnt_en    = 1'b1;
          if (cnt_tc) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state register and no output other than o_dout is combinational.
  always_ff @(posedge i_sysclk or negedge i_sysrst) begin
    if (!i_sysrst) begin
      state  <= IDLE;
      shreg  <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      o_busy <= (state_nxt == SHIFT);
      o_done <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_shr_frame.sv
// tb_shr_frame: self-checking bench for shr_frame. Three instances share the
// same stimulus: MSB-first serial, LSB-first serial, and MSB-first rotate.
// Each is tracked by a behavioural frame model and compared every cycle.
module tb_shr_frame;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             din = 1'b0;
  logic             sh = 1'b0;
  logic             ld = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       ld_data = 8'h00;
  logic [2:0]       dout;
  logic [2:0]       busy;
  logic [2:0]       done;
  logic [2:0][7:0]  dstr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shr_frame #(.WIDTH(8), .MSB_FIRST(1), .FEEDBACK(0)) dut_msb (
    .i_sysclk(clk), .i_sysrst(rst_n), .i_din(din), .i_sh(sh), .i_ld(ld),
    .i_start(start), .i_ld_data(ld_data), .o_dout(dout[0]), .o_dstr(dstr[0]),
    .o_busy(busy[0]), .o_done(done[0]));

  shr_frame #(.WIDTH(8), .MSB_FIRST(0), .FEEDBACK(0)) dut_lsb (
    .i_sysclk(clk), .i_sysrst(rst_n), .i_din(din), .i_sh(sh), .i_ld(ld),
    .i_start(start), .i_ld_data(ld_data), .o_dout(dout[1]), .o_dstr(dstr[1]),
    .o_busy(busy[1]), .o_done(done[1]));

  shr_frame #(.WIDTH(8), .MSB_FIRST(1), .FEEDBACK(1)) dut_rot (
    .i_sysclk(clk), .i_sysrst(rst_n), .i_din(din), .i_sh(sh), .i_ld(ld),
    .i_start(start), .i_ld_data(ld_data), .o_dout(dout[2]), .o_dstr(dstr[2]),
    .o_busy(busy[2]), .o_done(done[2]));

  // Reference model: word value, whether a frame is in flight, bits left in
  // the frame, and the completion pulse.
  int         cfg_msb [3] = '{1, 0, 1};
  int         cfg_fb  [3] = '{0, 0, 1};
  logic [7:0] m_reg    [3];
  bit         m_active [3];
  bit         m_done   [3];
  int         m_left   [3];

  function automatic logic m_dout(input int k);
    int v;
    v = int'(m_reg[k]);
    return (cfg_msb[k] != 0) ? logic'((v / 128) % 2) : logic'(v % 2);
  endfunction

  function automatic logic [10:0] m_obs(input int k);
    return {m_reg[k], m_dout(k), logic'(m_active[k]), logic'(m_done[k])};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_reg[k] = 8'h00; m_active[k] = 0; m_done[k] = 0; m_left[k] = 0;
    end
  endtask

  task automatic model_edge();
    int v;
    int b;
    logic [7:0] nv;
    for (int k = 0; k < 3; k++) begin
      v = int'(m_reg[k]);
      b = (cfg_fb[k] != 0) ? int'(m_dout(k)) : int'(din);
      nv = (cfg_msb[k] != 0) ? 8'((v * 2 + b) % 256) : 8'(v / 2 + b * 128);
      if (m_done[k]) begin
        m_done[k] = 0;
      end else if (m_active[k]) begin
        if (sh) begin
          m_reg[k] = nv;
          m_left[k] = m_left[k] - 1;
          if (m_left[k] == 0) begin
            m_active[k] = 0;
            m_done[k] = 1;
          end
        end
      end else if (start) begin
        m_reg[k] = ld_data; m_active[k] = 1; m_left[k] = 8;
      end else if (ld) begin
        m_reg[k] = ld_data;
      end else if (sh) begin
        m_reg[k] = nv;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, sample at +1.
  task automatic step(input logic d, input logic s, input logic l,
                      input logic st, input logic [7:0] data);
    din = d; sh = s; ld = l; start = st; ld_data = data;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({dstr[k], dout[k], busy[k], done[k]} !== 11'h000) begin
        failures++;
        $display("[TB] FAIL reset_async dut%0d got=%h want=%h", k,
                 {dstr[k], dout[k], busy[k], done[k]}, 11'h000);
      end
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({dstr[k], dout[k], busy[k], done[k]} !== 11'h000) begin
        failures++;
        $display("[TB] FAIL reset_held dut%0d got=%h want=%h", k,
                 {dstr[k], dout[k], busy[k], done[k]}, 11'h000);
      end
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({dstr[k], dout[k], busy[k], done[k]} !== m_obs(k)) begin
        failures++;
        $display("[TB] FAIL reset_release dut%0d got=%h want=%h", k,
                 {dstr[k], dout[k], busy[k], done[k]}, m_obs(k));
      end
    end
  endtask

  task automatic test_frame_msb();
    logic [7:0] word;
    word = 8'hA5;
    step(1'b1, 1'b0, 1'b0, 1'b1, word);
    checks++;
    if (dout[0] !== 1'b1 || busy[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL msb_first_bit dout/busy got=%b%b want=11", dout[0], busy[0]);
    end
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({dstr[k], dout[k], busy[k], done[k]} !== m_obs(k)) begin
          failures++;
          $display("[TB] FAIL msb_frame dut%0d shift%0d got=%h want=%h", k, i,
                   {dstr[k], dout[k], busy[k], done[k]}, m_obs(k));
        end
      end
      checks++;
      if (i < 8) begin
        if ({dout[0], busy[0], done[0]} !== {word[7-i], 2'b10}) begin
          failures++;
          $display("[TB] FAIL msb_seq shift%0d got=%b want=%b", i,
                   {dout[0], busy[0], done[0]}, {word[7-i], 2'b10});
        end
      end else if ({dstr[0], busy[0], done[0]} !== {8'hFF, 2'b01}) begin
        failures++;
        $display("[TB] FAIL msb_done got=%h want=%h", {dstr[0], busy[0], done[0]},
                 {8'hFF, 2'b01});
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (done[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_one_cycle got=%b want=0", done[0]);
    end
  endtask

  task automatic test_frame_lsb();
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
    checks++;
    if (dout[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL lsb_first_bit got=%b want=1", dout[1]);
    end
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      checks++;
      if (dout[1] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL lsb_seq shift%0d got=%b want=0", i, dout[1]);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({dstr[k], dout[k], busy[k], done[k]} !== m_obs(k)) begin
          failures++;
          $display("[TB] FAIL lsb_frame dut%0d shift%0d got=%h want=%h", k, i,
                   {dstr[k], dout[k], busy[k], done[k]}, m_obs(k));
        end
      end
    end
    checks++;
    if ({dstr[1], done[1]} !== {8'h00, 1'b1}) begin
      failures++;
      $display("[TB] FAIL lsb_done got=%h want=%h", {dstr[1], done[1]}, {8'h00, 1'b1});
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_rotate();
    step(1'($urandom), 1'b0, 1'b0, 1'b1, 8'h81);
    for (int i = 1; i <= 8; i++) begin
      step(1'($urandom), 1'b1, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({dstr[k], dout[k], busy[k], done[k]} !== m_obs(k)) begin
          failures++;
          $display("[TB] FAIL rotate_frame dut%0d shift%0d got=%h want=%h", k, i,
                   {dstr[k], dout[k], busy[k], done[k]}, m_obs(k));
        end
      end
    end
    checks++;
    if ({dstr[2], done[2]} !== {8'h81, 1'b1}) begin
      failures++;
      $display("[TB] FAIL rotate_done got=%h want=%h", {dstr[2], done[2]}, {8'h81, 1'b1});
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_sparse_shift();
    int pulses;
    int done_seen;
    int done_at;
    pulses = 0; done_seen = 0; done_at = -1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom));
    for (int c = 0; c < 36; c++) begin
      if (c % 4 == 3) pulses++;
      step(1'($urandom), logic'(c % 4 == 3), 1'($urandom), 1'($urandom), 8'($urandom));
      if (done[0] === 1'b1) begin
        done_seen++;
        done_at = pulses;
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({dstr[k], dout[k], busy[k], done[k]} !== m_obs(k)) begin
          failures++;
          $display("[TB] FAIL sparse_frame dut%0d cycle%0d got=%h want=%h", k, c,
                   {dstr[k], dout[k], busy[k], done[k]}, m_obs(k));
        end
      end
      if (done_seen > 0) break;
    end
    checks++;
    if (done_seen !== 1 || done_at !== 8) begin
      failures++;
      $display("[TB] FAIL sparse_done count=%0d after_pulse=%0d want count=1 after_pulse=8",
               done_seen, done_at);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_start_ignored();
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 3; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'($urandom), 1'b0, 1'b1, 1'b1, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({dstr[k], dout[k], busy[k], done[k]} !== m_obs(k)) begin
        failures++;
        $display("[TB] FAIL start_in_shift dut%0d got=%h want=%h", k,
                 {dstr[k], dout[k], busy[k], done[k]}, m_obs(k));
      end
    end
    for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({dstr[2], done[2]} !== {8'h3C, 1'b1}) begin
      failures++;
      $display("[TB] FAIL start_ignored_rot got=%h want=%h", {dstr[2], done[2]}, {8'h3C, 1'b1});
    end
    checks++;
    if ({dstr[0], done[0]} !== {m_reg[0], 1'b1}) begin
      failures++;
      $display("[TB] FAIL start_ignored_msb got=%h want=%h", {dstr[0], done[0]}, {m_reg[0], 1'b1});
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h12);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({dstr[k], busy[k]} !== {8'h12, 1'b1}) begin
        failures++;
        $display("[TB] FAIL start_beats_ld dut%0d got=%h want=%h", k,
                 {dstr[k], busy[k]}, {8'h12, 1'b1});
      end
    end
    for (int i = 0; i < 9; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_midframe();
    int done_seen;
    done_seen = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom_range(1, 255)));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({dstr[k], dout[k], busy[k], done[k]} !== 11'h000) begin
        failures++;
        $display("[TB] FAIL midframe_reset dut%0d got=%h want=%h", k,
                 {dstr[k], dout[k], busy[k], done[k]}, 11'h000);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'($urandom), 1'b1, 1'b0, 1'b0, 8'h00);
      if (done !== 3'b000) done_seen++;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({dstr[k], dout[k], busy[k], done[k]} !== m_obs(k)) begin
          failures++;
          $display("[TB] FAIL after_reset dut%0d cycle%0d got=%h want=%h", k, i,
                   {dstr[k], dout[k], busy[k], done[k]}, m_obs(k));
        end
      end
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("[TB] FAIL no_done_after_reset got=%0d want=0", done_seen);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 9) == 0),
           8'($urandom));
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({dstr[k], dout[k], busy[k], done[k]} !== m_obs(k)) begin
          failures++;
          $display("[TB] FAIL random dut%0d cycle%0d got=%h want=%h", k, c,
                   {dstr[k], dout[k], busy[k], done[k]}, m_obs(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_msb();
    test_frame_lsb();
    test_rotate();
    test_sparse_shift();
    test_start_ignored();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
